// File: rtl/bc_pkg.sv
// Shared definitions for the basic computer datapath registers.
// Holds the register operation encoding and the default word width.
// No logic; imported by bc_register and its users.
package bc_pkg;

  localparam int BC_WORD_W = 16;

  // Operation selected for a register on a given edge, highest priority first.
  typedef enum logic [2:0] {
    OP_RST,
    OP_CLR,
    OP_LD,
    OP_INR,
    OP_DEC,
    OP_SHR,
    OP_SHL,
    OP_HOLD
  } bc_reg_op_t;

endpackage

// File: rtl/bc_dff.sv
// 1-bit D flip-flop with synchronous active-high reset to RST_VAL.
// Latency: d appears on q one rising edge later. No flow control.
// Ports: clk, rst (sync, active-high), d (next value), q (stored bit).
module bc_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/bc_register.sv
// General-purpose WIDTH-bit register: clear, load, inc, dec, shift right/left.
// Latency: one edge for every operation; q and cout update together. No backpressure.
// Ports: clk, rst, controls clr/ld/inr/dec/shr/shl, sin, d -> q, cout, zero.
module bc_register
  import bc_pkg::*;
#(
  parameter int                WIDTH       = BC_WORD_W,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             inr,
  input  logic             dec,
  input  logic             shr,
  input  logic             shl,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  bc_reg_op_t       op;
  logic [WIDTH-1:0] q_n;
  logic             cout_n;

  // Priority encoder: exactly one operation wins per edge.
  always_comb begin
    op = OP_HOLD;
    if      (rst) op = OP_RST;
    else if (clr) op = OP_CLR;
    else if (ld)  op = OP_LD;
    else if (inr) op = OP_INR;
    else if (dec) op = OP_DEC;
    else if (shr) op = OP_SHR;
    else if (shl) op = OP_SHL;
  end

  // Next-state mux for {cout, q}.
  always_comb begin
    q_n    = q;
    cout_n = cout;
    case (op)
      OP_RST: begin q_n = RESET_VALUE;          cout_n = 1'b0;         end
      OP_CLR: begin q_n = '0;                   cout_n = 1'b0;         end
      OP_LD:  begin q_n = d;                    cout_n = 1'b0;         end
      OP_INR: begin q_n = q + ONE;              cout_n = &q;           end // carry on all-ones wrap
      OP_DEC: begin q_n = q - ONE;              cout_n = ~|q;          end // borrow on zero wrap
      OP_SHR: begin q_n = {sin, q[WIDTH-1:1]};  cout_n = q[0];         end
      OP_SHL: begin q_n = {q[WIDTH-2:0], sin};  cout_n = q[WIDTH-1];   end
      default: begin q_n = q;                   cout_n = cout;         end
    endcase
  end

  // Per-bit storage; reset is also applied inside each flop so the reset
  // value does not depend on the mux path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bc_dff #(.RST_VAL(RESET_VALUE[i])) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (q_n[i]),
      .q   (q[i])
    );
  end

  bc_dff #(.RST_VAL(1'b0)) u_cout_dff (
    .clk (clk),
    .rst (rst),
    .d   (cout_n),
    .q   (cout)
  );

  assign zero = ~|q;

endmodule

// File: tb/tb_bc_register.sv
// Self-checking bench for bc_register (WIDTH=16, RESET_VALUE=16'h00FF).
// Each operation pushes a predicted {q, cout, zero} into a scoreboard queue
// that is popped and compared one clock later.
module tb_bc_register;

  localparam int          W  = 16;
  localparam logic [15:0] RV = 16'h00FF;

  // Control vector order: {rst, clr, ld, inr, dec, shr, shl}
  localparam logic [6:0] C_HOLD = 7'b0000000;
  localparam logic [6:0] C_SHL  = 7'b0000001;
  localparam logic [6:0] C_SHR  = 7'b0000010;
  localparam logic [6:0] C_DEC  = 7'b0000100;
  localparam logic [6:0] C_INR  = 7'b0001000;
  localparam logic [6:0] C_LD   = 7'b0010000;
  localparam logic [6:0] C_CLR  = 7'b0100000;
  localparam logic [6:0] C_RST  = 7'b1000000;

  typedef struct {
    logic [15:0] q;
    logic        c;
    logic        z;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, clr, ld, inr, dec, shr, shl, sin;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          cout;
  logic          zero;

  exp_t          sb[$];
  logic [15:0]   mq;
  logic          mc;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  bc_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .ld   (ld),
    .inr  (inr),
    .dec  (dec),
    .shr  (shr),
    .shl  (shl),
    .sin  (sin),
    .d    (d),
    .q    (q),
    .cout (cout),
    .zero (zero)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the operation table.
  task automatic model(input logic [6:0] c, input logic s, input logic [15:0] dv);
    logic [15:0] oq;
    oq = mq;
    if (c[6])      begin mq = RV;                 mc = 1'b0;            end
    else if (c[5]) begin mq = 16'h0000;           mc = 1'b0;            end
    else if (c[4]) begin mq = dv;                 mc = 1'b0;            end
    else if (c[3]) begin mq = oq + 16'd1;         mc = (oq == 16'hFFFF); end
    else if (c[2]) begin mq = oq - 16'd1;         mc = (oq == 16'h0000); end
    else if (c[1]) begin mq = {s, oq[15:1]};      mc = oq[0];           end
    else if (c[0]) begin mq = {oq[14:0], s};      mc = oq[15];          end
  endtask

  task automatic step(input string tag, input logic [6:0] c, input logic s, input logic [15:0] dv);
    exp_t e;
    @(negedge clk);
    {rst, clr, ld, inr, dec, shr, shl} = c;
    sin = s;
    d   = dv;
    model(c, s, dv);
    e.q = mq; e.c = mc; e.z = (mq == 16'h0000);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_q"},    q,            e.q);
    check({tag, "_cout"}, {15'd0, cout}, {15'd0, e.c});
    check({tag, "_zero"}, {15'd0, zero}, {15'd0, e.z});
  endtask

  initial begin
    logic [6:0] rc;
    logic       held_c;
    {rst, clr, ld, inr, dec, shr, shl, sin} = '0;
    d  = '0;
    mq = '0;
    mc = 1'b0;

    // Reset beats a simultaneous load.
    step("rst", C_RST | C_LD, 1'b0, 16'h1234);
    check("rst_abs_q", q, 16'h00FF);
    check("rst_abs_zero", {15'd0, zero}, 16'd0);

    // Increment wrap.
    step("ld_fffe", C_LD, 1'b0, 16'hFFFE);
    step("inr1", C_INR, 1'b0, 16'h0);
    check("inr1_abs", {q[14:0], cout}, {15'h7FFF, 1'b0});
    step("inr2", C_INR, 1'b0, 16'h0);
    check("inr2_abs", {q[14:0], cout}, {15'h0000, 1'b1});
    check("inr2_abs_zero", {15'd0, zero}, 16'd1);

    // Decrement wrap.
    step("clr", C_CLR, 1'b0, 16'h0);
    step("dec1", C_DEC, 1'b0, 16'h0);
    check("dec1_abs", {q[14:0], cout}, {15'h7FFF, 1'b1});
    step("dec2", C_DEC, 1'b0, 16'h0);
    check("dec2_abs", {q[14:0], cout}, {15'h7FFE, 1'b0});

    // Shifts.
    step("ld_8001", C_LD, 1'b0, 16'h8001);
    step("shr", C_SHR, 1'b1, 16'h0);
    check("shr_abs_q", q, 16'hC000);
    step("shl", C_SHL, 1'b0, 16'h0);
    check("shl_abs_q", q, 16'h8000);
    check("shl_abs_cout", {15'd0, cout}, 16'd1);

    // Priority.
    step("ld_5", C_LD, 1'b0, 16'h0005);
    step("clr_ld_inr", C_CLR | C_LD | C_INR, 1'b0, 16'h00AA);
    check("prio_clr_abs", q, 16'h0000);
    step("ld_inr", C_LD | C_INR, 1'b0, 16'h00AA);
    check("prio_ld_abs", q, 16'h00AA);

    // Hold, then reset in the middle of a continuous increment.
    step("ld_10", C_LD, 1'b0, 16'h0010);
    held_c = cout;
    for (int i = 0; i < 3; i++) step("hold", C_HOLD, 1'b1, 16'hFFFF);
    check("hold_abs_q", q, 16'h0010);
    check("hold_abs_cout", {15'd0, cout}, {15'd0, held_c});
    step("inr_a", C_INR, 1'b0, 16'h0);
    step("inr_b", C_INR, 1'b0, 16'h0);
    step("inr_rst", C_INR | C_RST, 1'b0, 16'h0);
    check("midrst_abs", q, 16'h00FF);
    step("inr_after", C_INR, 1'b0, 16'h0);
    check("midrst_next_abs", q, 16'h0100);

    // Random mix; ANDed draws keep few controls active and rst rare.
    for (int i = 0; i < 300; i++) begin
      rc = 7'($urandom) & 7'($urandom) & 7'($urandom);
      if (rc[6] && ($urandom_range(0, 3) != 0)) rc[6] = 1'b0;
      step("rand", rc, 1'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
